// File: rtl/fpga_soc_reset_sequencer_if.sv
// Board-pin and SoC-side signal bundle of the reset sequencer.
// The sequencer takes the master modport; the board/SoC wrapper takes the slave modport.
interface fpga_soc_reset_sequencer_if;
  logic        btn_rst_i;
  logic        pll_locked_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        soc_rst_no;
  logic [31:0] exit_value_o;
  logic        exit_done_o;
  logic        rst_led_o;
  logic        clk_led_o;
  logic        status_led_o;
  logic        wdt_fired_o;

  modport master (
    input  btn_rst_i,
    input  pll_locked_i,
    input  exit_valid_i,
    input  exit_value_i,
    output soc_rst_no,
    output exit_value_o,
    output exit_done_o,
    output rst_led_o,
    output clk_led_o,
    output status_led_o,
    output wdt_fired_o
  );

  modport slave (
    output btn_rst_i,
    output pll_locked_i,
    output exit_valid_i,
    output exit_value_i,
    input  soc_rst_no,
    input  exit_value_o,
    input  exit_done_o,
    input  rst_led_o,
    input  clk_led_o,
    input  status_led_o,
    input  wdt_fired_o
  );
endinterface

// File: rtl/fpga_soc_reset_sequencer.sv
// SoC reset sequencer: qualifies button/PLL lock, stretches SoC reset, latches exit status, drives LEDs.
// Optional run-time watchdog is enabled by defining FPGA_RST_WATCHDOG_EN.
module fpga_soc_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int RESET_HOLD_CYCLES    = 64,
  parameter int CLK_LED_COUNT_LENGTH = 27,
  parameter int FAIL_BLINK_BIT       = 22,
  parameter int WATCHDOG_CYCLES      = 2**30
) (
  input  logic clk_i,
  input  logic rst_i,
  fpga_soc_reset_sequencer_if.master io
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || RESET_HOLD_CYCLES < 1 || WATCHDOG_CYCLES < 2 ||
      FAIL_BLINK_BIT < 0 || FAIL_BLINK_BIT >= CLK_LED_COUNT_LENGTH) begin : g_bad_params
    $error("fpga_soc_reset_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic btn_meta, btn_sync;
  logic lock_meta, lock_sync;
  logic btn_q;
  logic [DEB_W-1:0] deb_cnt;
  logic deb_flip;
  logic hold_req;

  logic [CLK_LED_COUNT_LENGTH-1:0] hb_cnt, hb_cnt_nxt;

  state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [31:0] exit_value_q, exit_value_nxt;
  logic exit_done_q, exit_done_nxt;
  logic soc_rst_q, soc_rst_nxt;
  logic status_q, status_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      btn_meta  <= io.btn_rst_i;
      btn_sync  <= btn_meta;
      lock_meta <= io.pll_locked_i;
      lock_sync <= lock_meta;
    end
  end

  // The accepted button level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  assign deb_flip = (btn_sync != btn_q) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_q   <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_sync == btn_q) begin
      deb_cnt <= '0;
    end else if (deb_flip) begin
      btn_q   <= btn_sync;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Lock loss is taken as-is: a glitchy PLL should hold the SoC in reset anyway.
  assign hold_req = btn_q | ~lock_sync;

  assign hb_cnt_nxt = hb_cnt + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hb_cnt <= '0;
    else       hb_cnt <= hb_cnt_nxt;
  end

`ifdef FPGA_RST_WATCHDOG_EN
  localparam int WDT_W = $clog2(WATCHDOG_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WATCHDOG_CYCLES - 1);

  logic [WDT_W-1:0] run_cnt;
  logic wdt_set;
  logic wdt_fired_q;
  logic btn_rise;

  assign btn_rise = deb_flip & btn_sync;
`endif

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = '0;
    exit_value_nxt = exit_value_q;
    exit_done_nxt  = exit_done_q;
`ifdef FPGA_RST_WATCHDOG_EN
    wdt_set        = 1'b0;
`endif
    case (state)
      ST_HOLD: begin
        if (!hold_req) begin
          if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
          else                       hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (hold_req) begin
          state_nxt = ST_HOLD;
        end else if (io.exit_valid_i) begin
          exit_value_nxt = io.exit_value_i;
          exit_done_nxt  = 1'b1;
          state_nxt      = ST_DONE;
        end
`ifdef FPGA_RST_WATCHDOG_EN
        else if (run_cnt == WDT_LAST) begin
          state_nxt = ST_HOLD;
          wdt_set   = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (hold_req) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_HOLD;
    endcase

    if (state_nxt == ST_HOLD) begin
      exit_value_nxt = '0;
      exit_done_nxt  = 1'b0;
    end

    soc_rst_nxt = (state_nxt != ST_HOLD);
    // Solid on pass, blinking on a nonzero exit code.
    if (state_nxt == ST_DONE)
      status_nxt = (exit_value_nxt == 32'd0) ? 1'b1 : hb_cnt_nxt[FAIL_BLINK_BIT];
    else
      status_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      exit_value_q <= '0;
      exit_done_q  <= 1'b0;
      soc_rst_q    <= 1'b0;
      status_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      exit_value_q <= exit_value_nxt;
      exit_done_q  <= exit_done_nxt;
      soc_rst_q    <= soc_rst_nxt;
      status_q     <= status_nxt;
    end
  end

`ifdef FPGA_RST_WATCHDOG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cnt     <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      if (state_nxt == ST_RUN && state != ST_RUN) run_cnt <= '0;
      else if (state == ST_RUN)                   run_cnt <= run_cnt + 1'b1;

      if (wdt_set)       wdt_fired_q <= 1'b1;
      else if (btn_rise) wdt_fired_q <= 1'b0;
    end
  end

  assign io.wdt_fired_o = wdt_fired_q;
`else
  assign io.wdt_fired_o = 1'b0;
`endif

  assign io.soc_rst_no   = soc_rst_q;
  assign io.rst_led_o    = soc_rst_q;
  assign io.exit_value_o = exit_value_q;
  assign io.exit_done_o  = exit_done_q;
  assign io.status_led_o = status_q;
  assign io.clk_led_o    = hb_cnt[CLK_LED_COUNT_LENGTH-1];

endmodule

// File: tb/tb_fpga_soc_reset_sequencer.sv
// Directed bench for fpga_soc_reset_sequencer with small LED counter and fast blink for simulation.
`timescale 1ns/1ps
module tb_fpga_soc_reset_sequencer;
  localparam int DEB   = 16;
  localparam int HOLD  = 64;
  localparam int LEDW  = 6;
  localparam int BLINK = 3;
  localparam int WDT   = 200;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [31:0] cyc;
  int errors = 0;
  int checks = 0;

  fpga_soc_reset_sequencer_if bus();

  fpga_soc_reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(HOLD),
    .CLK_LED_COUNT_LENGTH(LEDW),
    .FAIL_BLINK_BIT(BLINK),
    .WATCHDOG_CYCLES(WDT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .io(bus)
  );

  always #5 clk_i = ~clk_i;

  // Edges since reset release; the heartbeat counter value is cyc modulo 2**LEDW.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc <= '0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.btn_rst_i    = 1'b0;
    bus.pll_locked_i = 1'b1;
    bus.exit_valid_i = 1'b0;
    bus.exit_value_i = 32'd0;
    tick(2);
    check("rst_soc_rst_no",   32'(bus.soc_rst_no),   32'd0);
    check("rst_exit_done",    32'(bus.exit_done_o),  32'd0);
    check("rst_exit_value",   bus.exit_value_o,      32'd0);
    check("rst_rst_led",      32'(bus.rst_led_o),    32'd0);
    check("rst_clk_led",      32'(bus.clk_led_o),    32'd0);
    check("rst_status_led",   32'(bus.status_led_o), 32'd0);
    check("rst_wdt_fired",    32'(bus.wdt_fired_o),  32'd0);

    // Release: lock_sync high after 2 edges, SoC released 64 edges later.
    rst_i = 1'b0;
    tick(65);
    check("rel_still_held",   32'(bus.soc_rst_no),   32'd0);
    check("rel_led_off",      32'(bus.rst_led_o),    32'd0);
    tick(1);
    check("rel_released",     32'(bus.soc_rst_no),   32'd1);
    check("rel_led_on",       32'(bus.rst_led_o),    32'd1);
    check("rel_clk_led_66",   32'(bus.clk_led_o),    32'd0);
    tick(34);
    check("hb_clk_led_100",   32'(bus.clk_led_o),    32'd1);

    // Pass exit, then a later exit pulse must be ignored.
    bus.exit_valid_i = 1'b1;
    bus.exit_value_i = 32'd0;
    tick(1);
    bus.exit_valid_i = 1'b0;
    check("pass_done",        32'(bus.exit_done_o),  32'd1);
    check("pass_value",       bus.exit_value_o,      32'd0);
    check("pass_status",      32'(bus.status_led_o), 32'd1);
    tick(9);
    check("pass_status_solid", 32'(bus.status_led_o), 32'd1);
    bus.exit_valid_i = 1'b1;
    bus.exit_value_i = 32'd5;
    tick(1);
    bus.exit_valid_i = 1'b0;
    check("pass_frozen_value", bus.exit_value_o,     32'd0);
    check("pass_frozen_done", 32'(bus.exit_done_o),  32'd1);

    // Lock loss: 2 synchroniser edges then HOLD on the third.
    bus.pll_locked_i = 1'b0;
    tick(2);
    check("lock_soc_still_run", 32'(bus.soc_rst_no), 32'd1);
    tick(1);
    check("lock_soc_held",    32'(bus.soc_rst_no),   32'd0);
    check("lock_done_clear",  32'(bus.exit_done_o),  32'd0);
    check("lock_status_off",  32'(bus.status_led_o), 32'd0);
    bus.pll_locked_i = 1'b1;
    tick(65);
    check("relock_held",      32'(bus.soc_rst_no),   32'd0);
    tick(1);
    check("relock_released",  32'(bus.soc_rst_no),   32'd1);

    // Fail exit: status blinks with heartbeat bit BLINK.
    bus.exit_valid_i = 1'b1;
    bus.exit_value_i = 32'h1;
    tick(1);
    bus.exit_valid_i = 1'b0;
    bus.exit_value_i = 32'd0;
    check("fail_done",        32'(bus.exit_done_o),  32'd1);
    check("fail_value",       bus.exit_value_o,      32'h1);
    check("fail_status",      32'(bus.status_led_o), 32'(cyc[BLINK]));
    for (int i = 0; i < 24; i++) begin
      tick(1);
      check("fail_blink",     32'(bus.status_led_o), 32'(cyc[BLINK]));
    end
    bus.pll_locked_i = 1'b0;
    tick(3);
    check("fail_lock_held",   32'(bus.soc_rst_no),   32'd0);
    check("fail_lock_done",   32'(bus.exit_done_o),  32'd0);
    check("fail_lock_value",  bus.exit_value_o,      32'd0);
    check("fail_lock_status", 32'(bus.status_led_o), 32'd0);
    bus.pll_locked_i = 1'b1;
    tick(66);
    check("fail_relock",      32'(bus.soc_rst_no),   32'd1);

    // Bouncing button never accepted.
    for (int i = 0; i < 20; i++) begin
      bus.btn_rst_i = ~bus.btn_rst_i;
      tick(5);
      check("bounce_no_reset", 32'(bus.soc_rst_no),  32'd1);
    end
    // Steady press: 2 sync + 16 debounce + 1 FSM edges.
    bus.btn_rst_i = 1'b1;
    tick(18);
    check("btn_not_yet",      32'(bus.soc_rst_no),   32'd1);
    tick(1);
    check("btn_reset",        32'(bus.soc_rst_no),   32'd0);
    check("btn_reset_led",    32'(bus.rst_led_o),    32'd0);
    tick(1);
    bus.btn_rst_i = 1'b0;
    tick(81);
    check("btn_rel_held",     32'(bus.soc_rst_no),   32'd0);
    tick(1);
    check("btn_rel_released", 32'(bus.soc_rst_no),   32'd1);

    // Debounced press and exit in the same cycle: HOLD wins.
    bus.btn_rst_i = 1'b1;
    tick(18);
    check("sim_pre",          32'(bus.soc_rst_no),   32'd1);
    bus.exit_valid_i = 1'b1;
    bus.exit_value_i = 32'd7;
    tick(1);
    bus.exit_valid_i = 1'b0;
    bus.exit_value_i = 32'd0;
    check("sim_held",         32'(bus.soc_rst_no),   32'd0);
    check("sim_done",         32'(bus.exit_done_o),  32'd0);
    check("sim_value",        bus.exit_value_o,      32'd0);
    bus.btn_rst_i = 1'b0;
    tick(81);
    check("sim_rel_held",     32'(bus.soc_rst_no),   32'd0);
    tick(1);
    check("sim_rel_released", 32'(bus.soc_rst_no),   32'd1);
    check("sim_rel_done",     32'(bus.exit_done_o),  32'd0);

`ifdef FPGA_RST_WATCHDOG_EN
    tick(199);
    check("wdt_not_yet",      32'(bus.soc_rst_no),   32'd1);
    check("wdt_flag_low",     32'(bus.wdt_fired_o),  32'd0);
    tick(1);
    check("wdt_reset",        32'(bus.soc_rst_no),   32'd0);
    check("wdt_flag",         32'(bus.wdt_fired_o),  32'd1);
    tick(63);
    check("wdt_rel_held",     32'(bus.soc_rst_no),   32'd0);
    tick(1);
    check("wdt_rel_released", 32'(bus.soc_rst_no),   32'd1);
    check("wdt_flag_sticky",  32'(bus.wdt_fired_o),  32'd1);
    bus.btn_rst_i = 1'b1;
    tick(18);
    check("wdt_btn_clear",    32'(bus.wdt_fired_o),  32'd0);
    bus.btn_rst_i = 1'b0;
    tick(83);
    check("wdt_btn_released", 32'(bus.soc_rst_no),   32'd1);
`else
    tick(200);
    check("nowdt_run",        32'(bus.soc_rst_no),   32'd1);
    check("nowdt_flag",       32'(bus.wdt_fired_o),  32'd0);
    tick(100);
    check("nowdt_run_late",   32'(bus.soc_rst_no),   32'd1);
    check("nowdt_flag_late",  32'(bus.wdt_fired_o),  32'd0);
`endif

    // Asynchronous reset takes effect without a clock edge.
    rst_i = 1'b1;
    #1;
    check("arst_soc",         32'(bus.soc_rst_no),   32'd0);
    check("arst_led",         32'(bus.rst_led_o),    32'd0);
    check("arst_clk_led",     32'(bus.clk_led_o),    32'd0);
    tick(2);
    rst_i = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
